// File: rtl/ex_mem_wb_regs.sv
// EX/MEM and MEM/WB pipeline registers with stall hold, bubble insertion,
// branch flush (including a flush deferred across a memory stall) and
// forwarding-friendly destination masking on the outputs.
module ex_mem_wb_regs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memStall,
  input  logic              flush,
  input  logic              EX_regWrite,
  input  logic              EX_memRead,
  input  logic              EX_memWrite,
  input  logic              EX_memToReg,
  input  logic [REG_W-1:0]  EX_rd,
  input  logic [REG_W-1:0]  EX_rt,
  input  logic [DATA_W-1:0] EX_aluResult,
  input  logic [DATA_W-1:0] EX_storeData,
  input  logic [DATA_W-1:0] MEM_readData,
  output logic              EX_MEM_regWrite,
  output logic              EX_MEM_memRead,
  output logic              EX_MEM_memWrite,
  output logic [REG_W-1:0]  EX_MEM_rd,
  output logic [DATA_W-1:0] EX_MEM_aluResult,
  output logic [DATA_W-1:0] EX_MEM_storeData,
  output logic              MEM_WB_regWrite,
  output logic [REG_W-1:0]  MEM_WB_rd,
  output logic [REG_W-1:0]  MEM_WB_rt,
  output logic [DATA_W-1:0] MEM_WB_writeData,
  output logic              MEM_WB_valid,
  output logic              flushPending
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] write_data;
  } mem_wb_t;

  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    pend_flush_q, pend_flush_d;
  logic    flush_apply;

  // Next-state: a stall freezes EX/MEM and drains a bubble into MEM/WB;
  // otherwise both stages advance, with EX/MEM squashed on a live or deferred flush.
  always_comb begin
    ex_mem_d     = ex_mem_q;
    mem_wb_d     = '0;
    pend_flush_d = pend_flush_q;
    flush_apply  = flush | pend_flush_q;

    if (memStall) begin
      pend_flush_d = pend_flush_q | flush;
    end else begin
      mem_wb_d.valid      = ex_mem_q.valid;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_read   = ex_mem_q.mem_read;
      mem_wb_d.rd         = ex_mem_q.rd;
      mem_wb_d.rt         = ex_mem_q.rt;
      mem_wb_d.write_data = ex_mem_q.mem_to_reg ? MEM_readData : ex_mem_q.alu_result;
      pend_flush_d        = 1'b0;
      if (flush_apply) begin
        ex_mem_d = '0;
      end else begin
        ex_mem_d.valid      = 1'b1;
        ex_mem_d.reg_write  = EX_regWrite;
        ex_mem_d.mem_read   = EX_memRead;
        ex_mem_d.mem_write  = EX_memWrite;
        ex_mem_d.mem_to_reg = EX_memToReg;
        ex_mem_d.rd         = EX_rd;
        ex_mem_d.rt         = EX_rt;
        ex_mem_d.alu_result = EX_aluResult;
        ex_mem_d.store_data = EX_storeData;
      end
    end
  end

  // Stage registers and deferred-flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q     <= '0;
      mem_wb_q     <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  // Outputs straight from flops; loads hide rd so only the rt compare can hit in MEM/WB.
  assign EX_MEM_regWrite  = ex_mem_q.reg_write;
  assign EX_MEM_memRead   = ex_mem_q.mem_read;
  assign EX_MEM_memWrite  = ex_mem_q.mem_write;
  assign EX_MEM_rd        = ex_mem_q.mem_read ? '0 : ex_mem_q.rd;
  assign EX_MEM_aluResult = ex_mem_q.alu_result;
  assign EX_MEM_storeData = ex_mem_q.store_data;
  assign MEM_WB_regWrite  = mem_wb_q.reg_write;
  assign MEM_WB_rd        = mem_wb_q.mem_read ? '0 : mem_wb_q.rd;
  assign MEM_WB_rt        = mem_wb_q.mem_read ? mem_wb_q.rt : '0;
  assign MEM_WB_writeData = mem_wb_q.write_data;
  assign MEM_WB_valid     = mem_wb_q.valid;
  assign flushPending     = pend_flush_q;

endmodule

// File: tb/tb_ex_mem_wb_regs.sv
// Directed bench for ex_mem_wb_regs: reset, forwarding masks, stall, flush,
// flush-during-stall and asynchronous reset mid-stream.
module tb_ex_mem_wb_regs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              memStall, flush;
  logic              EX_regWrite, EX_memRead, EX_memWrite, EX_memToReg;
  logic [REG_W-1:0]  EX_rd, EX_rt;
  logic [DATA_W-1:0] EX_aluResult, EX_storeData, MEM_readData;
  logic              EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite;
  logic [REG_W-1:0]  EX_MEM_rd;
  logic [DATA_W-1:0] EX_MEM_aluResult, EX_MEM_storeData;
  logic              MEM_WB_regWrite;
  logic [REG_W-1:0]  MEM_WB_rd, MEM_WB_rt;
  logic [DATA_W-1:0] MEM_WB_writeData;
  logic              MEM_WB_valid, flushPending;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_wb_regs #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .memStall(memStall), .flush(flush),
    .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
    .EX_memWrite(EX_memWrite), .EX_memToReg(EX_memToReg),
    .EX_rd(EX_rd), .EX_rt(EX_rt), .EX_aluResult(EX_aluResult),
    .EX_storeData(EX_storeData), .MEM_readData(MEM_readData),
    .EX_MEM_regWrite(EX_MEM_regWrite), .EX_MEM_memRead(EX_MEM_memRead),
    .EX_MEM_memWrite(EX_MEM_memWrite), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_aluResult(EX_MEM_aluResult), .EX_MEM_storeData(EX_MEM_storeData),
    .MEM_WB_regWrite(MEM_WB_regWrite), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_rt(MEM_WB_rt), .MEM_WB_writeData(MEM_WB_writeData),
    .MEM_WB_valid(MEM_WB_valid), .flushPending(flushPending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ex_mem_regWrite"},  32'(EX_MEM_regWrite),  32'h0);
    check({tag, " ex_mem_memRead"},   32'(EX_MEM_memRead),   32'h0);
    check({tag, " ex_mem_memWrite"},  32'(EX_MEM_memWrite),  32'h0);
    check({tag, " ex_mem_rd"},        32'(EX_MEM_rd),        32'h0);
    check({tag, " ex_mem_alu"},       EX_MEM_aluResult,      32'h0);
    check({tag, " ex_mem_store"},     EX_MEM_storeData,      32'h0);
    check({tag, " mem_wb_regWrite"},  32'(MEM_WB_regWrite),  32'h0);
    check({tag, " mem_wb_rd"},        32'(MEM_WB_rd),        32'h0);
    check({tag, " mem_wb_rt"},        32'(MEM_WB_rt),        32'h0);
    check({tag, " mem_wb_wdata"},     MEM_WB_writeData,      32'h0);
    check({tag, " mem_wb_valid"},     32'(MEM_WB_valid),     32'h0);
    check({tag, " flushPending"},     32'(flushPending),     32'h0);
  endtask

  // Drive one EX-stage instruction: {regWrite, memRead, memWrite, memToReg}, rd, rt, alu, store
  task automatic drive(input logic [3:0] ctl, input logic [4:0] rd, input logic [4:0] rt,
                       input logic [31:0] alu, input logic [31:0] st);
    {EX_regWrite, EX_memRead, EX_memWrite, EX_memToReg} = ctl;
    EX_rd = rd; EX_rt = rt; EX_aluResult = alu; EX_storeData = st;
  endtask

  // Advance one active edge and return to the sampling point.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    memStall = 1'b0; flush = 1'b0; MEM_readData = '0;
    // Random inputs under reset must not leak to outputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memStall = 1'($urandom); flush = 1'($urandom);
      drive(4'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
      MEM_readData = $urandom;
    end
    @(negedge clk);
    check_all_zero("reset");

    rst_n = 1'b1; memStall = 1'b0; flush = 1'b0;
    // R-type rd=8
    drive(4'b1000, 5'd8, 5'd2, 32'h1234, 32'h0);
    step();
    check("rtype ex_mem_rd", 32'(EX_MEM_rd), 32'd8);
    check("rtype ex_mem_regWrite", 32'(EX_MEM_regWrite), 32'd1);
    check("rtype ex_mem_alu", EX_MEM_aluResult, 32'h1234);

    // lw rt=9 rd=3 follows
    drive(4'b1101, 5'd3, 5'd9, 32'h100, 32'h0);
    MEM_readData = 32'h7777;
    step();
    check("rtype mem_wb_rd", 32'(MEM_WB_rd), 32'd8);
    check("rtype mem_wb_rt", 32'(MEM_WB_rt), 32'd0);
    check("rtype mem_wb_wdata", MEM_WB_writeData, 32'h1234);
    check("rtype mem_wb_valid", 32'(MEM_WB_valid), 32'd1);
    check("lw ex_mem_rd masked", 32'(EX_MEM_rd), 32'd0);
    check("lw ex_mem_memRead", 32'(EX_MEM_memRead), 32'd1);

    // 3-cycle stall with lw held in EX/MEM
    memStall = 1'b1;
    drive(4'b1000, 5'd20, 5'd21, 32'hDEAD, 32'h0);
    MEM_readData = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall ex_mem_memRead", 32'(EX_MEM_memRead), 32'd1);
      check("stall ex_mem_alu", EX_MEM_aluResult, 32'h100);
      check("stall ex_mem_rd", 32'(EX_MEM_rd), 32'd0);
      check("stall mem_wb_valid", 32'(MEM_WB_valid), 32'd0);
      check("stall mem_wb_regWrite", 32'(MEM_WB_regWrite), 32'd0);
      check("stall flushPending", 32'(flushPending), 32'd0);
    end

    // Stall drops; simultaneously flush an add rd=5
    memStall = 1'b0; flush = 1'b1;
    MEM_readData = 32'hBEEF;
    drive(4'b1000, 5'd5, 5'd1, 32'h5555, 32'h0);
    step();
    check("lw mem_wb_wdata", MEM_WB_writeData, 32'hBEEF);
    check("lw mem_wb_rt", 32'(MEM_WB_rt), 32'd9);
    check("lw mem_wb_rd masked", 32'(MEM_WB_rd), 32'd0);
    check("lw mem_wb_valid", 32'(MEM_WB_valid), 32'd1);
    check("lw mem_wb_regWrite", 32'(MEM_WB_regWrite), 32'd1);
    check("flush ex_mem_regWrite", 32'(EX_MEM_regWrite), 32'd0);
    check("flush ex_mem_rd", 32'(EX_MEM_rd), 32'd0);
    check("flush ex_mem_alu", EX_MEM_aluResult, 32'h0);

    flush = 1'b0;
    drive(4'b1000, 5'd6, 5'd1, 32'h66, 32'h0);
    step();
    check("flush bubble mem_wb_valid", 32'(MEM_WB_valid), 32'd0);
    check("flush bubble mem_wb_regWrite", 32'(MEM_WB_regWrite), 32'd0);
    check("add6 ex_mem_rd", 32'(EX_MEM_rd), 32'd6);

    // Flush arrives while stalled: deferred
    memStall = 1'b1; flush = 1'b1;
    drive(4'b1000, 5'd7, 5'd1, 32'h77, 32'h0);
    step();
    check("stallflush pending", 32'(flushPending), 32'd1);
    check("stallflush ex_mem_rd held", 32'(EX_MEM_rd), 32'd6);
    flush = 1'b0;
    step();
    check("stallflush pending kept", 32'(flushPending), 32'd1);
    check("stallflush ex_mem_alu held", EX_MEM_aluResult, 32'h66);

    memStall = 1'b0;
    drive(4'b1000, 5'd10, 5'd1, 32'hAA, 32'h0);
    step();
    check("deferred flush ex_mem_regWrite", 32'(EX_MEM_regWrite), 32'd0);
    check("deferred flush ex_mem_rd", 32'(EX_MEM_rd), 32'd0);
    check("deferred flush cleared", 32'(flushPending), 32'd0);
    check("add6 mem_wb_rd", 32'(MEM_WB_rd), 32'd6);
    check("add6 mem_wb_wdata", MEM_WB_writeData, 32'h66);
    check("add6 mem_wb_valid", 32'(MEM_WB_valid), 32'd1);

    drive(4'b1000, 5'd11, 5'd1, 32'hBB, 32'h0);
    step();
    check("post-flush ex_mem_rd", 32'(EX_MEM_rd), 32'd11);
    check("post-flush mem_wb_valid", 32'(MEM_WB_valid), 32'd0);

    // sw with rd11 moving to WB
    drive(4'b0010, 5'd12, 5'd4, 32'h40, 32'h55);
    step();
    check("sw ex_mem_memWrite", 32'(EX_MEM_memWrite), 32'd1);
    check("sw ex_mem_store", EX_MEM_storeData, 32'h55);
    check("add11 mem_wb_rd", 32'(MEM_WB_rd), 32'd11);
    check("add11 mem_wb_wdata", MEM_WB_writeData, 32'hBB);

    // Leave a pending flush recorded, then reset asynchronously between edges
    memStall = 1'b1; flush = 1'b1;
    step();
    check("pre-reset pending", 32'(flushPending), 32'd1);
    check("pre-reset ex_mem_memWrite", 32'(EX_MEM_memWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    check_all_zero("reset held");

    // Release: first edge is a normal load, no stale flush
    rst_n = 1'b1; memStall = 1'b0; flush = 1'b0;
    drive(4'b1000, 5'd13, 5'd1, 32'hD0, 32'h0);
    step();
    check("post-reset ex_mem_rd", 32'(EX_MEM_rd), 32'd13);
    check("post-reset ex_mem_regWrite", 32'(EX_MEM_regWrite), 32'd1);
    check("post-reset mem_wb_valid", 32'(MEM_WB_valid), 32'd0);
    drive(4'b0000, 5'd0, 5'd0, 32'h0, 32'h0);
    step();
    check("post-reset mem_wb_rd", 32'(MEM_WB_rd), 32'd13);
    check("post-reset mem_wb_valid2", 32'(MEM_WB_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
